// File: rtl/ysyx_22040386_csr_pkg.sv
// Shared CSR definitions for the machine-mode trap path: CSR addresses,
// mstatus bit positions, cause codes and trap-sequencer state encodings.
package ysyx_22040386_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MIE_MTIE       = 7;

    localparam logic [63:0] CAUSE_ECALL_M = 64'd11;
    localparam logic [63:0] CAUSE_MTI     = 64'h8000_0000_0000_0007;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T_EPC,
        ST_T_CAUSE,
        ST_T_STATUS,
        ST_T_JUMP,
        ST_R_STATUS,
        ST_R_JUMP
    } trap_state_e;

    // Winner of the acceptance priority encode in IDLE.
    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_IRQ,
        SEL_ECALL,
        SEL_MRET
    } trap_sel_e;

endpackage

// File: rtl/ysyx_22040386_trap_pending.sv
// Qualifies the CLINT timer interrupt and picks the highest-priority trap
// event (irq > ecall > mret) for the instruction at commit.
module ysyx_22040386_trap_pending
    import ysyx_22040386_csr_pkg::*;
(
    input  logic      i_PEND_valid,
    input  logic      i_PEND_ecall,
    input  logic      i_PEND_mret,
    input  logic      i_PEND_mtip,
    input  logic      i_PEND_mstatus_mie,
    input  logic      i_PEND_mie_mtie,
    output logic      o_PEND_irq,
    output trap_sel_e o_PEND_sel
);

    always_comb begin
        o_PEND_irq = i_PEND_valid & i_PEND_mtip & i_PEND_mstatus_mie & i_PEND_mie_mtie;
        o_PEND_sel = SEL_NONE;
        if (o_PEND_irq) begin
            o_PEND_sel = SEL_IRQ;
        end else if (i_PEND_valid && i_PEND_ecall) begin
            o_PEND_sel = SEL_ECALL;
        end else if (i_PEND_valid && i_PEND_mret) begin
            o_PEND_sel = SEL_MRET;
        end
    end

endmodule

// File: rtl/ysyx_22040386_trap_ctrl.sv
// Trap sequencer: on ecall/irq writes mepc, mcause, mstatus then jumps to
// mtvec; on mret restores mstatus then jumps to mepc. Stalls commit meanwhile.
module ysyx_22040386_trap_ctrl
    import ysyx_22040386_csr_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            i_TRAP_clk,
    input  logic            i_TRAP_rst,
    input  logic            i_TRAP_valid,
    input  logic            i_TRAP_ecall,
    input  logic            i_TRAP_mret,
    input  logic [XLEN-1:0] i_TRAP_pc,
    input  logic            i_TRAP_mtip,
    input  logic [XLEN-1:0] i_TRAP_mstatus,
    input  logic [XLEN-1:0] i_TRAP_mie,
    input  logic [XLEN-1:0] i_TRAP_mtvec,
    input  logic [XLEN-1:0] i_TRAP_mepc,
    output logic            o_TRAP_busy,
    output logic            o_TRAP_squash,
    output logic            o_TRAP_csr_wen,
    output logic [11:0]     o_TRAP_csr_waddr,
    output logic [XLEN-1:0] o_TRAP_csr_wdata,
    output logic            o_TRAP_redirect,
    output logic [XLEN-1:0] o_TRAP_target
);

    trap_state_e     r_state;
    trap_state_e     w_next;
    trap_sel_e       w_sel;
    logic            w_idle;
    logic            w_irq;
    logic            w_accept;
    logic            w_unused;

    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_mstatus;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mepc;

    logic [XLEN-1:0] w_trap_status;
    logic [XLEN-1:0] w_ret_status;
    logic            w_wen;
    logic [11:0]     w_waddr;
    logic [XLEN-1:0] w_wdata;
    logic            w_redirect;
    logic [XLEN-1:0] w_target;

    assign w_idle = (r_state == ST_IDLE);

    // Gating valid with IDLE masks ecall/mret/mtip for the whole busy window.
    ysyx_22040386_trap_pending u_pending (
        .i_PEND_valid       (i_TRAP_valid & w_idle),
        .i_PEND_ecall       (i_TRAP_ecall),
        .i_PEND_mret        (i_TRAP_mret),
        .i_PEND_mtip        (i_TRAP_mtip),
        .i_PEND_mstatus_mie (i_TRAP_mstatus[MSTATUS_MIE]),
        .i_PEND_mie_mtie    (i_TRAP_mie[MIE_MTIE]),
        .o_PEND_irq         (w_irq),
        .o_PEND_sel         (w_sel)
    );

    assign w_accept      = (w_sel != SEL_NONE);
    assign o_TRAP_busy   = !w_idle | w_accept;
    assign o_TRAP_squash = w_accept & w_irq;

    assign w_unused = ^{i_TRAP_mie, r_mtvec[1:0]};

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                unique case (w_sel)
                    SEL_IRQ, SEL_ECALL: w_next = ST_T_EPC;
                    SEL_MRET:           w_next = ST_R_STATUS;
                    default:            w_next = ST_IDLE;
                endcase
            end
            ST_T_EPC:    w_next = ST_T_CAUSE;
            ST_T_CAUSE:  w_next = ST_T_STATUS;
            ST_T_STATUS: w_next = ST_T_JUMP;
            ST_R_STATUS: w_next = ST_R_JUMP;
            default:     w_next = ST_IDLE;
        endcase
    end

    // The mret status is built from the live input because R_STATUS is only
    // ever entered from the acceptance cycle, before the snapshot lands.
    always_comb begin
        w_trap_status                                = r_mstatus;
        w_trap_status[MSTATUS_MPIE]                  = r_mstatus[MSTATUS_MIE];
        w_trap_status[MSTATUS_MIE]                   = 1'b0;
        w_trap_status[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

        w_ret_status                                 = i_TRAP_mstatus;
        w_ret_status[MSTATUS_MIE]                    = i_TRAP_mstatus[MSTATUS_MPIE];
        w_ret_status[MSTATUS_MPIE]                   = 1'b1;
        w_ret_status[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
    end

    always_comb begin
        w_wen      = 1'b0;
        w_waddr    = '0;
        w_wdata    = '0;
        w_redirect = 1'b0;
        w_target   = '0;
        unique case (w_next)
            ST_T_EPC: begin
                w_wen   = 1'b1;
                w_waddr = CSR_MEPC;
                w_wdata = i_TRAP_pc;
            end
            ST_T_CAUSE: begin
                w_wen   = 1'b1;
                w_waddr = CSR_MCAUSE;
                w_wdata = r_cause;
            end
            ST_T_STATUS, ST_R_STATUS: begin
                w_wen   = 1'b1;
                w_waddr = CSR_MSTATUS;
                w_wdata = (w_next == ST_T_STATUS) ? w_trap_status : w_ret_status;
            end
            ST_T_JUMP: begin
                w_redirect = 1'b1;
                w_target   = {r_mtvec[XLEN-1:2], 2'b00};
            end
            ST_R_JUMP: begin
                w_redirect = 1'b1;
                w_target   = r_mepc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_TRAP_clk) begin
        if (i_TRAP_rst) begin
            r_state          <= ST_IDLE;
            r_cause          <= '0;
            r_mstatus        <= '0;
            r_mtvec          <= '0;
            r_mepc           <= '0;
            o_TRAP_csr_wen   <= 1'b0;
            o_TRAP_csr_waddr <= '0;
            o_TRAP_csr_wdata <= '0;
            o_TRAP_redirect  <= 1'b0;
            o_TRAP_target    <= '0;
        end else begin
            r_state          <= w_next;
            o_TRAP_csr_wen   <= w_wen;
            o_TRAP_csr_waddr <= w_waddr;
            o_TRAP_csr_wdata <= w_wdata;
            o_TRAP_redirect  <= w_redirect;
            o_TRAP_target    <= w_target;
            if (w_accept) begin
                r_cause   <= w_irq ? XLEN'(CAUSE_MTI) : XLEN'(CAUSE_ECALL_M);
                r_mstatus <= i_TRAP_mstatus;
                r_mtvec   <= i_TRAP_mtvec;
                r_mepc    <= i_TRAP_mepc;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040386_trap_ctrl.sv
// Self-checking bench for the trap sequencer: directed scenarios plus random
// traps, checked cycle by cycle against a transaction-level expectation list.
module tb_ysyx_22040386_trap_ctrl;

    logic        clk;
    logic        rst;
    logic        valid, ecall, mret, mtip;
    logic [63:0] pc, mstatus, mie, mtvec, mepc;
    logic        busy, squash, wen, redirect;
    logic [11:0] waddr;
    logic [63:0] wdata, target;

    int checkCount;
    int passCount;

    typedef struct {
        logic        busy;
        logic        squash;
        logic        wen;
        logic [11:0] waddr;
        logic [63:0] wdata;
        logic        redirect;
        logic [63:0] target;
    } exp_t;

    ysyx_22040386_trap_ctrl #(.XLEN(64)) dut (
        .i_TRAP_clk       (clk),
        .i_TRAP_rst       (rst),
        .i_TRAP_valid     (valid),
        .i_TRAP_ecall     (ecall),
        .i_TRAP_mret      (mret),
        .i_TRAP_pc        (pc),
        .i_TRAP_mtip      (mtip),
        .i_TRAP_mstatus   (mstatus),
        .i_TRAP_mie       (mie),
        .i_TRAP_mtvec     (mtvec),
        .i_TRAP_mepc      (mepc),
        .o_TRAP_busy      (busy),
        .o_TRAP_squash    (squash),
        .o_TRAP_csr_wen   (wen),
        .o_TRAP_csr_waddr (waddr),
        .o_TRAP_csr_wdata (wdata),
        .o_TRAP_redirect  (redirect),
        .o_TRAP_target    (target)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Architectural mstatus updates written as plain arithmetic on the value.
    function automatic logic [63:0] trapStatus(input logic [63:0] s);
        return (s & ~64'h88) | ((s << 4) & 64'h80) | 64'h1800;
    endfunction

    function automatic logic [63:0] retStatus(input logic [63:0] s);
        return (s & ~64'h8) | ((s >> 4) & 64'h8) | 64'h1880;
    endfunction

    function automatic exp_t quietExp();
        exp_t e;
        e.busy = 0; e.squash = 0; e.wen = 0; e.waddr = '0;
        e.wdata = '0; e.redirect = 0; e.target = '0;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic checkCycle(input string tag, input exp_t e);
        checkOutput({tag, ".busy"},     busy,     e.busy);
        checkOutput({tag, ".squash"},   squash,   e.squash);
        checkOutput({tag, ".wen"},      wen,      e.wen);
        checkOutput({tag, ".redirect"}, redirect, e.redirect);
        if (e.wen) begin
            checkOutput({tag, ".waddr"}, waddr, e.waddr);
            checkOutput({tag, ".wdata"}, wdata, e.wdata);
        end
        if (e.redirect) checkOutput({tag, ".target"}, target, e.target);
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic e,
                                 input logic m, input logic t,
                                 input logic [63:0] p, input logic [63:0] ms,
                                 input logic [63:0] ie, input logic [63:0] tv,
                                 input logic [63:0] ep);
        @(negedge clk);
        rst = r; valid = v; ecall = e; mret = m; mtip = t;
        pc = p; mstatus = ms; mie = ie; mtvec = tv; mepc = ep;
        #2;
    endtask

    task automatic applyNoise();
        applyStimulus(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      rand64(), rand64(), rand64(), rand64(), rand64());
    endtask

    // Drives one commit-point instruction, then checks every cycle of the
    // resulting trap sequence while hammering the inputs with random noise.
    task automatic runSequence(input string name, input logic v, input logic e,
                               input logic m, input logic t,
                               input logic [63:0] p, input logic [63:0] ms,
                               input logic [63:0] ie, input logic [63:0] tv,
                               input logic [63:0] ep);
        exp_t q[$];
        exp_t x;
        logic irq;
        irq = v & t & ms[3] & ie[7];
        x = quietExp();
        x.busy = v & (irq | e | m);
        x.squash = irq;
        q.push_back(x);
        if (v && (irq || e)) begin
            x = quietExp(); x.busy = 1; x.wen = 1; x.waddr = 12'h341; x.wdata = p;
            q.push_back(x);
            x.waddr = 12'h342;
            x.wdata = irq ? 64'h8000_0000_0000_0007 : 64'd11;
            q.push_back(x);
            x.waddr = 12'h300; x.wdata = trapStatus(ms);
            q.push_back(x);
            x = quietExp(); x.busy = 1; x.redirect = 1; x.target = tv & ~64'h3;
            q.push_back(x);
        end else if (v && m) begin
            x = quietExp(); x.busy = 1; x.wen = 1; x.waddr = 12'h300;
            x.wdata = retStatus(ms);
            q.push_back(x);
            x = quietExp(); x.busy = 1; x.redirect = 1; x.target = ep;
            q.push_back(x);
        end
        applyStimulus(0, v, e, m, t, p, ms, ie, tv, ep);
        checkCycle($sformatf("%s.c0", name), q[0]);
        for (int c = 1; c < q.size(); c++) begin
            applyNoise();
            checkCycle($sformatf("%s.c%0d", name, c), q[c]);
        end
        applyStimulus(0, 0, 0, 0, 0, '0, '0, '0, '0, '0);
        checkCycle($sformatf("%s.after", name), quietExp());
    endtask

    initial begin
        exp_t z;
        clk = 0; rst = 1; valid = 0; ecall = 0; mret = 0; mtip = 0;
        pc = '0; mstatus = '0; mie = '0; mtvec = '0; mepc = '0;
        checkCount = 0; passCount = 0;
        z = quietExp();

        applyStimulus(1, 0, 0, 0, 0, '0, '0, '0, '0, '0);
        applyStimulus(1, 0, 0, 0, 0, '0, '0, '0, '0, '0);
        checkCycle("reset", z);
        checkOutput("reset.waddr",  waddr,  '0);
        checkOutput("reset.wdata",  wdata,  '0);
        checkOutput("reset.target", target, '0);

        runSequence("ecall", 1, 1, 0, 0, 64'h8000_0010, 64'h8, 64'h0,
                    64'h8000_0100, 64'h0);
        runSequence("mret", 1, 0, 1, 0, 64'h8000_0030, 64'h1880, 64'h0,
                    64'h8000_0100, 64'h8000_0014);
        runSequence("irq", 1, 0, 0, 1, 64'h8000_0020, 64'h8, 64'h80,
                    64'h8000_0103, 64'h0);
        runSequence("irqMasked", 1, 0, 0, 1, 64'h8000_0020, 64'h0, 64'h80,
                    64'h8000_0100, 64'h0);
        runSequence("irqNoMtie", 1, 0, 0, 1, 64'h8000_0020, 64'h8, 64'h0,
                    64'h8000_0100, 64'h0);
        runSequence("irqOverEcall", 1, 1, 1, 1, 64'h8000_0040, 64'h8, 64'h80,
                    64'h8000_0200, 64'h1234);
        runSequence("ecallOverMret", 1, 1, 1, 0, 64'h8000_0044, 64'h0, 64'h0,
                    64'h8000_0300, 64'h5678);
        runSequence("invalid", 0, 1, 1, 1, 64'h8000_0048, 64'h8, 64'h80,
                    64'h8000_0300, 64'h0);

        // Reset lands at cycle 2 of an ecall: nothing further may appear.
        applyStimulus(0, 1, 1, 0, 0, 64'h8000_0050, 64'h8, 64'h0, 64'h8000_0400, 64'h0);
        z.busy = 1;
        checkCycle("midReset.c0", z);
        applyStimulus(0, 0, 0, 0, 0, '0, '0, '0, '0, '0);
        checkOutput("midReset.c1.wen", wen, 1);
        applyStimulus(1, 0, 0, 0, 0, '0, '0, '0, '0, '0);
        checkOutput("midReset.c2.wen", wen, 1);
        checkOutput("midReset.c2.waddr", waddr, 12'h342);
        z = quietExp();
        for (int c = 3; c < 7; c++) begin
            applyStimulus(0, 0, 0, 0, 0, '0, '0, '0, '0, '0);
            checkCycle($sformatf("midReset.c%0d", c), z);
            checkOutput($sformatf("midReset.c%0d.waddr", c), waddr, '0);
            checkOutput($sformatf("midReset.c%0d.target", c), target, '0);
        end
        runSequence("postReset", 1, 1, 0, 0, 64'h8000_0060, 64'h8, 64'h0,
                    64'h8000_0500, 64'h0);

        for (int i = 0; i < 40; i++) begin
            runSequence($sformatf("rand%0d", i), 1'($urandom_range(0, 3) != 0),
                        1'($urandom), 1'($urandom), 1'($urandom),
                        rand64(), rand64(), rand64(), rand64(), rand64());
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
